nios2_jtag_debug_scan_initiator: RTL
====================================

# nios2_jtag_debug_scan_initiator

Synchronous scan initiator for the Nios II JTAG debug module's virtual-JTAG port: the host-side counterpart of the debug module's capture/shift/update logic. It accepts one IR/DR command at a time over a valid/ready interface and generates the virtual-JTAG sequence towards the debug module: UIR, CDR, SDR shifting and UDR, plus RTI when enabled. It returns the 38-bit word shifted out of the debug module's `sr`. It replaces the physical `sld_virtual_jtag_basic` for on-chip self-test and simulation, driving the `vji_*` nets directly.

## Interface
Parameters:
- `IR_WIDTH`, 2, instruction register width
- `DR_WIDTH`, 38, data register width (matches `sr`/`jdo`)
- `TCK_DIV`, 2, clk cycles per tck half-period, ≥1
- `RTI_CYCLES`, 1, tck periods spent in RTI (used only with the RTI feature)

Ports:
- `clk` in 1: system clock; all logic on its rising edge
- `reset_n` in 1: reset, synchronous, active-low
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command accepted when high with `cmd_valid`
- `cmd_ir` in IR_WIDTH: instruction to load
- `cmd_dr` in DR_WIDTH: data to shift in, LSB first
- `rsp_valid` out 1: captured data available
- `rsp_ready` in 1: response consumed
- `rsp_dr` out DR_WIDTH: bits shifted out of `vji_tdo`; first bit lands in bit 0
- `vji_tck` out 1: generated test clock
- `vji_tdi` out 1: serial data to the debug module
- `vji_tdo` in 1: serial data from the debug module
- `vji_ir_in` out IR_WIDTH: current instruction
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti` out 1 each: virtual state flags

## Operation
- States: IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP.
- Each state except IDLE and RESP lasts whole tck periods. One tck period is 2·TCK_DIV clk cycles: low half first, then high half.
- IDLE: `cmd_ready` = 1 unless `rsp_valid`. On `cmd_valid & cmd_ready`:
  - latch `cmd_ir` into `vji_ir_in`
  - latch `cmd_dr` into the shift register
  - clear the bit counter
  - go to UIR
- UIR: `vji_uir` = 1 for 1 tck period → CDR.
- CDR: `vji_cdr` = 1 for 1 tck period → SHIFT.
- SHIFT: `vji_sdr` = 1 for DR_WIDTH tck periods.
  - At the start of each period (tck falling), `vji_tdi` = `sr[0]`.
  - At tck rising, `vji_tdo` is sampled into `sr[DR_WIDTH-1]` and `sr` shifts right.
  - Bit counter counts 0..DR_WIDTH-1; after the last period → UDR.
- UDR: `vji_udr` = 1 for 1 tck period → RTI if enabled, else RESP.
- RTI: `vji_rti` = 1 for RTI_CYCLES tck periods → RESP.
- RESP:
  - `rsp_dr` = `sr` and `rsp_valid` = 1, held until `rsp_ready`.
  - `vji_ir_in` retains its value until the next command.
  - Go to IDLE.
- State flags are mutually exclusive and are never asserted in IDLE or RESP.
- `vji_tck` is held at 0 in IDLE and RESP.

## Timing
- Reset values:
  - all `vji_*` outputs = 0
  - `rsp_valid` = 0, `rsp_dr` = 0
  - `cmd_ready` = 1 in the first cycle after reset deassertion
- Reset asserted mid-scan: every output returns to its reset value at the next clk edge. The partial scan is abandoned and no response is produced.
- Latency from accept to `rsp_valid`:
  - without RTI: (3 + DR_WIDTH)·2·TCK_DIV clk cycles
  - with RTI: add RTI_CYCLES·2·TCK_DIV
  - defaults without RTI: 164 cycles
- `cmd_ready` is low from accept until the cycle after the `rsp_valid & rsp_ready` handshake.
- If `rsp_ready` and `cmd_valid` are high in the same cycle, the response is consumed that cycle and the command is accepted in the next cycle.
- `cmd_valid` while busy has no effect.
- `vji_tdi` changes only on tck falling edges. `vji_tdo` is sampled in the clk cycle where tck rises.
- TCK_DIV = 1 gives tck = clk/2.

## Configuration
- `NIOS2_JTAG_SCAN_RTI_EN` defined:
  - RTI state compiled in
  - `vji_rti` is pulsed for RTI_CYCLES tck periods after UDR
- `NIOS2_JTAG_SCAN_RTI_EN` undefined:
  - RTI state removed
  - `vji_rti` tied to 0
  - UDR goes directly to RESP

## Structure
- Shared package `nios2_jtag_dbg_pkg` holds:
  - state enum
  - default widths (IR 2, DR 38)
  - IR codes: OCIMEM = 2'b00, TRACE = 2'b01, BREAK = 2'b10, ENABLE = 2'b11
- One sub-module, `nios2_jtag_tck_gen`:
  - half-period counter with enable
  - outputs `tck`, `tck_rise`, `tck_fall` (one clk cycle each)
  - held low and reset when disabled

## Test plan
- Reset while in SHIFT at bit 10 → next cycle all `vji_*` = 0, `rsp_valid` = 0, `cmd_ready` = 1.
- `vji_tdo` tied 1, cmd_ir = 2'b00, cmd_dr = 0 → `rsp_dr` = 38'h3F_FFFF_FFFF. `vji_tdi` is 0 for all 38 SHIFT periods, and `vji_ir_in` = 2'b00 from UIR onward.
- Bench model shifts out 38'h2_1234_5678 LSB first on tck falling; cmd_dr = 38'h1_AAAA_5555 → `rsp_dr` = 38'h2_1234_5678. The model captures 38'h1_AAAA_5555 on UDR.
- Defaults, RTI disabled → `rsp_valid` rises exactly 164 clk cycles after accept. `vji_uir`, `vji_cdr` and `vji_udr` each high for 4 cycles; `vji_sdr` high for 152 cycles.
- `rsp_ready` held 0 for 20 cycles while `cmd_valid` = 1 → `cmd_ready` stays 0 and `rsp_dr` is stable. Raise `rsp_ready` → the second command is accepted on the following cycle.
- With `NIOS2_JTAG_SCAN_RTI_EN` and RTI_CYCLES = 3 → `vji_rti` high for 12 cycles immediately after UDR; latency 176 cycles.

Source files
------------

// File: rtl/nios2_jtag_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug scan initiator.
// Holds the scan FSM state enum, default register widths, the debug
// module IR codes and a small helper function.
package nios2_jtag_dbg_pkg;

  localparam int DEF_IR_WIDTH = 2;
  localparam int DEF_DR_WIDTH = 38;

  // Debug module instruction codes
  localparam logic [1:0] IR_OCIMEM = 2'b00;
  localparam logic [1:0] IR_TRACE  = 2'b01;
  localparam logic [1:0] IR_BREAK  = 2'b10;
  localparam logic [1:0] IR_ENABLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nios2_jtag_tck_gen.sv
// Test clock generator for the scan initiator.
// One tck period is 2*TCK_DIV clk cycles, low half first. While en is low
// the phase counter is held at zero and tck stays low, so every enable
// starts on a fresh low half.
// Ports:
//   clk, reset_n : system clock, synchronous active-low reset
//   en           : run the test clock
//   tck          : generated test clock
//   tck_fall     : first clk cycle of a period (tck just went/stays low)
//   tck_rise     : first clk cycle of the high half
//   tck_last     : last clk cycle of a period
module nios2_jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall,
  output logic tck_last
);

  localparam int PERIOD = 2 * TCK_DIV;
  localparam int CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || !en)                cnt <= '0;
    else if (cnt == CW'(PERIOD - 1))    cnt <= '0;
    else                                cnt <= cnt + CW'(1);
  end

  assign tck      = en && (cnt >= CW'(TCK_DIV));
  assign tck_rise = en && (cnt == CW'(TCK_DIV));
  assign tck_fall = en && (cnt == '0);
  assign tck_last = en && (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/nios2_jtag_debug_scan_initiator.sv
// Host-side virtual-JTAG scan initiator for the Nios II JTAG debug module.
// Takes one IR/DR command over valid/ready, plays UIR, CDR, SHIFT (DR_WIDTH
// tck periods, LSB first), UDR and optionally RTI on the vji_* nets, then
// returns the word shifted out of vji_tdo over valid/ready.
// Optional feature: define NIOS2_JTAG_SCAN_RTI_EN to insert RTI_CYCLES tck
// periods of RTI after UDR; otherwise vji_rti is tied low.
// Ports:
//   clk, reset_n              : system clock, synchronous active-low reset
//   cmd_valid/ready/ir/dr     : command channel
//   rsp_valid/ready/dr        : response channel (first tdo bit in bit 0)
//   vji_tck/tdi/tdo/ir_in     : virtual JTAG clock, data and instruction
//   vji_uir/cdr/sdr/udr/rti   : virtual JTAG state flags
module nios2_jtag_debug_scan_initiator
  import nios2_jtag_dbg_pkg::*;
#(
  parameter int IR_WIDTH   = DEF_IR_WIDTH,
  parameter int DR_WIDTH   = DEF_DR_WIDTH,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  // One counter serves as SHIFT bit index and RTI period count.
  localparam int CNT_W = $clog2(max_int(DR_WIDTH, RTI_CYCLES) + 1);

  scan_state_e         state, state_nxt;
  logic [DR_WIDTH-1:0] sr;
  logic [CNT_W-1:0]    bit_cnt;
  logic                tdi_q;
  logic                tck_en, tck_rise, tck_fall, tck_last;
  logic                accept;

  assign accept = cmd_valid && cmd_ready;

  nios2_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (tck_en),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tck_last (tck_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: every scan state ends on the last clk of a tck period
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)   state_nxt = ST_UIR;
      ST_UIR:   if (tck_last) state_nxt = ST_CDR;
      ST_CDR:   if (tck_last) state_nxt = ST_SHIFT;
      ST_SHIFT: if (tck_last && bit_cnt == CNT_W'(DR_WIDTH - 1))
                  state_nxt = ST_UDR;
`ifdef NIOS2_JTAG_SCAN_RTI_EN
      ST_UDR:   if (tck_last) state_nxt = ST_RTI;
      ST_RTI:   if (tck_last && bit_cnt == CNT_W'(RTI_CYCLES - 1))
                  state_nxt = ST_RESP;
`else
      ST_UDR:   if (tck_last) state_nxt = ST_RESP;
`endif
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    tck_en    = (state != ST_IDLE) && (state != ST_RESP);
    vji_uir   = (state == ST_UIR);
    vji_cdr   = (state == ST_CDR);
    vji_sdr   = (state == ST_SHIFT);
    vji_udr   = (state == ST_UDR);
`ifdef NIOS2_JTAG_SCAN_RTI_EN
    vji_rti   = (state == ST_RTI);
`else
    vji_rti   = 1'b0;
`endif
    // sr[0] is the current bit until tck rises and shifts sr, so the bit
    // is presented straight from sr in the fall cycle and held afterwards.
    vji_tdi   = vji_sdr && (tck_fall ? sr[0] : tdi_q);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr        <= '0;
      bit_cnt   <= '0;
      tdi_q     <= 1'b0;
      rsp_dr    <= '0;
      vji_ir_in <= '0;
    end else begin
      // Period counter restarts on every state change
      if (state_nxt != state) bit_cnt <= '0;
      else if (tck_last)      bit_cnt <= bit_cnt + CNT_W'(1);

      if (accept) begin
        sr        <= cmd_dr;
        vji_ir_in <= cmd_ir;
      end else if (vji_sdr && tck_rise) begin
        sr <= {vji_tdo, sr[DR_WIDTH-1:1]};
      end

      if (vji_sdr && tck_fall) tdi_q <= sr[0];

      if (state != ST_RESP && state_nxt == ST_RESP) rsp_dr <= sr;
    end
  end

endmodule
